// File: rtl/red_peak_detector.sv
// RED-channel heartbeat detector: hysteresis max/min tracking of the FIR output,
// reporting peak/trough amplitudes and the peak-to-peak interval of each accepted beat.
module red_peak_detector #(
  parameter int unsigned DATA_W     = 20,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned HYST       = 512,
  parameter int unsigned WARMUP     = 25,
  parameter int unsigned MIN_PERIOD = 100,
  parameter int unsigned MAX_PERIOD = 1000
) (
  input  logic              CLK_Filter,
  input  logic              rst,
  input  logic [DATA_W-1:0] In_RED_Filtered,
  output logic [DATA_W-1:0] Peak_Value,
  output logic [DATA_W-1:0] Trough_Value,
  output logic [CNT_W-1:0]  Period,
  output logic              Beat_Valid,
  output logic              No_Beat
);

  localparam int unsigned       WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
  localparam logic [CNT_W-1:0]  MIN_V     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  MAX_V     = CNT_W'(MAX_PERIOD);
  localparam logic [DATA_W-1:0] HYST_V    = DATA_W'(HYST);

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_SEEK_MAX,
    ST_SEEK_MIN
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   run_max;
  logic [DATA_W-1:0]   run_min;
  logic [DATA_W-1:0]   trough_reg;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    age;
  logic                have_prev;
  logic [WARM_W-1:0]   warm;

  logic [DATA_W-1:0]   x;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    age_inc;
  logic [CNT_W-1:0]    interval;
  logic                raise;
  logic                peak_conf;
  logic                fall;
  logic                trough_conf;

  assign x           = In_RED_Filtered;
  assign cnt_inc     = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
  assign age_inc     = (age == CNT_SAT) ? age : age + CNT_W'(1);
  assign interval    = cnt - age;
  assign raise       = x > run_max;
  assign peak_conf   = (run_max - x) >= HYST_V;
  assign fall        = x < run_min;
  assign trough_conf = (x - run_min) >= HYST_V;

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      state        <= ST_WARMUP;
      run_max      <= '0;
      run_min      <= '0;
      trough_reg   <= '0;
      cnt          <= '0;
      age          <= '0;
      have_prev    <= 1'b0;
      warm         <= '0;
      Peak_Value   <= '0;
      Trough_Value <= '0;
      Period       <= '0;
      Beat_Valid   <= 1'b0;
      No_Beat      <= 1'b1;
    end else begin
      Beat_Valid <= 1'b0;
      if (state != ST_WARMUP) begin
        cnt <= cnt_inc;
        if (cnt > MAX_V) No_Beat <= 1'b1;
      end
      case (state)
        ST_WARMUP: begin
          if (warm == WARM_LAST) begin
            run_max <= x;
            run_min <= x;
            age     <= '0;
            state   <= ST_SEEK_MAX;
          end else begin
            warm <= warm + WARM_W'(1);
          end
        end
        ST_SEEK_MAX: begin
          if (raise) begin
            run_max <= x;
            age     <= '0;
          end else if (peak_conf) begin
            run_min <= x;
            state   <= ST_SEEK_MIN;
            // cnt advances this cycle too, so re-referencing to the peak loads age+1
            if (!have_prev) begin
              have_prev <= 1'b1;
              cnt       <= age_inc;
            end else if (interval >= MIN_V && interval <= MAX_V) begin
              Beat_Valid   <= 1'b1;
              Peak_Value   <= run_max;
              Trough_Value <= trough_reg;
              Period       <= interval;
              cnt          <= age_inc;
              No_Beat      <= 1'b0;
            end else if (interval > MAX_V) begin
              cnt <= age_inc;
            end
          end else begin
            age <= age_inc;
          end
        end
        ST_SEEK_MIN: begin
          if (fall) begin
            run_min <= x;
          end else if (trough_conf) begin
            trough_reg <= run_min;
            run_max    <= x;
            age        <= '0;
            state      <= ST_SEEK_MAX;
          end
        end
        default: state <= ST_WARMUP;
      endcase
    end
  end

endmodule
